// File: rtl/mix_columns_if.sv
// mix_columns_if
// Handshake bundle for the iterative AES MixColumns engine.
//   in_valid / in_ready / DataIn    : state accepted from ShiftRows
//   out_valid / out_ready / DataOut : mixed state offered to AddRoundKey
//   bypass                          : present only when MIXCOL_BYPASS_EN is defined
// Modports: master = upstream/downstream round logic, slave = the engine.
interface mix_columns_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] DataIn;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] DataOut;
`ifdef MIXCOL_BYPASS_EN
    logic         bypass;

    modport master (
        output in_valid, DataIn, out_ready, bypass,
        input  in_ready, out_valid, DataOut
    );

    modport slave (
        input  in_valid, DataIn, out_ready, bypass,
        output in_ready, out_valid, DataOut
    );
`else
    modport master (
        output in_valid, DataIn, out_ready,
        input  in_ready, out_valid, DataOut
    );

    modport slave (
        input  in_valid, DataIn, out_ready,
        output in_ready, out_valid, DataOut
    );
`endif
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq
// Iterative AES forward MixColumns. Accepts one 128-bit state, mixes
// COLS_PER_CYCLE columns per clock (N = 4/COLS_PER_CYCLE busy cycles) and
// holds the result until the downstream round logic takes it.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : mix_columns_if.slave (in_valid/in_ready/DataIn, out_valid/out_ready/DataOut)
// Column c occupies bits [127-32c -: 32]; row-0 byte is the MSB of a column.
// Parameter COLS_PER_CYCLE: 1, 2 or 4.
// Optional build macro MIXCOL_BYPASS_EN: adds bus.bypass, sampled on the
// accepting edge; when set, the latched input is passed through unchanged
// with identical timing (AES final round).
//
// state | meaning
// IDLE  | ready for a new state; in_ready=1
// BUSY  | mixing columns starting at colCnt
// DONE  | result held on DataOut; out_valid=1 until out_ready
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    mix_columns_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

    // With four columns per cycle the step wraps the 2-bit counter to 0,
    // and the last-column compare value is 0 as well, so one compare covers all widths.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    stateType     state;
    stateType     nextState;
    logic [1:0]   colCnt;
    logic [127:0] holdReg;
    logic [127:0] dataOutReg;
    logic [1:0]   colIdx    [COLS_PER_CYCLE];
    logic [31:0]  colResult [COLS_PER_CYCLE];
`ifdef MIXCOL_BYPASS_EN
    logic         bypassReg;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a, b, c, d;
        logic [7:0] a2, b2, c2, d2;
        {a, b, c, d} = col;
        a2 = xtime(a);
        b2 = xtime(b);
        c2 = xtime(c);
        d2 = xtime(d);
        return {a2 ^ (b2 ^ b) ^ c ^ d,
                a ^ b2 ^ (c2 ^ c) ^ d,
                a ^ b ^ c2 ^ (d2 ^ d),
                (a2 ^ a) ^ b ^ c ^ d2};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    nextState = BUSY;
                end
            end
            BUSY: begin
                if (colCnt == LAST_CNT) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Only COLS_PER_CYCLE mixers exist; each picks its column from the held input.
    always_comb begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            colIdx[j] = colCnt + 2'(j);
`ifdef MIXCOL_BYPASS_EN
            colResult[j] = bypassReg ? holdReg[127 - 32 * int'(colIdx[j]) -: 32]
                                     : mixColumn(holdReg[127 - 32 * int'(colIdx[j]) -: 32]);
`else
            colResult[j] = mixColumn(holdReg[127 - 32 * int'(colIdx[j]) -: 32]);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdReg    <= '0;
            dataOutReg <= '0;
            colCnt     <= '0;
`ifdef MIXCOL_BYPASS_EN
            bypassReg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        holdReg   <= bus.DataIn;
                        colCnt    <= '0;
`ifdef MIXCOL_BYPASS_EN
                        bypassReg <= bus.bypass;
`endif
                    end
                end
                BUSY: begin
                    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                        dataOutReg[127 - 32 * int'(colIdx[j]) -: 32] <= colResult[j];
                    end
                    colCnt <= colCnt + CNT_STEP;
                end
                default: ;
            endcase
        end
    end

    assign bus.DataOut = dataOutReg;

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic         outReady;
    logic [127:0] dataIn;
`ifdef MIXCOL_BYPASS_EN
    logic         bypassDrv;
`endif

    always #5 clk = ~clk;

    mix_columns_if bus1 ();
    mix_columns_if bus2 ();
    mix_columns_if bus4 ();

    assign bus1.in_valid  = inValid;
    assign bus2.in_valid  = inValid;
    assign bus4.in_valid  = inValid;
    assign bus1.DataIn    = dataIn;
    assign bus2.DataIn    = dataIn;
    assign bus4.DataIn    = dataIn;
    assign bus1.out_ready = outReady;
    assign bus2.out_ready = outReady;
    assign bus4.out_ready = outReady;
`ifdef MIXCOL_BYPASS_EN
    assign bus1.bypass = bypassDrv;
    assign bus2.bypass = bypassDrv;
    assign bus4.bypass = bypassDrv;
`endif

    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic         oValid [3];
    logic         iReady [3];
    logic [127:0] dOut   [3];
    assign oValid[0] = bus1.out_valid;
    assign oValid[1] = bus2.out_valid;
    assign oValid[2] = bus4.out_valid;
    assign iReady[0] = bus1.in_ready;
    assign iReady[1] = bus2.in_ready;
    assign iReady[2] = bus4.in_ready;
    assign dOut[0]   = bus1.DataOut;
    assign dOut[1]   = bus2.DataOut;
    assign dOut[2]   = bus4.DataOut;

    // Busy-cycle count N for COLS_PER_CYCLE = 1, 2, 4
    int busyN [3] = '{4, 2, 1};

    localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] V2 = 128'hc6c6c6c6_01010101_d4d4d4d5_00000000;
    localparam logic [127:0] E2 = 128'hc6c6c6c6_01010101_d5d5d7d6_00000000;
    localparam logic [127:0] V3 = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] E3 = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    logic [127:0] q2 [$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
    int           cyc = 0;
    int           acceptAt  [3] = '{0, 0, 0};
    logic         prevValid [3] = '{1'b0, 1'b0, 1'b0};
    logic [127:0] monExp;
    bit           monHave;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                // Accept is seen one falling edge before the accepting edge, so a
                // rise N edges after that edge appears N+1 falling edges later.
                if (oValid[k] && !prevValid[k]) begin
                    check($sformatf("latency_dut%0d", k), 128'(cyc - acceptAt[k]), 128'(busyN[k] + 1));
                end
                if (oValid[k] && outReady) begin
                    monHave = 1'b0;
                    monExp  = '0;
                    case (k)
                        0: if (q0.size() > 0) begin monExp = q0.pop_front(); monHave = 1'b1; end
                        1: if (q1.size() > 0) begin monExp = q1.pop_front(); monHave = 1'b1; end
                        default: if (q2.size() > 0) begin monExp = q2.pop_front(); monHave = 1'b1; end
                    endcase
                    if (monHave) begin
                        check($sformatf("dataout_dut%0d", k), dOut[k], monExp);
                    end else begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_output_dut%0d: got %h expected none", k, dOut[k]);
                    end
                end
                if (inValid && iReady[k]) begin
                    acceptAt[k] = cyc;
                end
            end
            prevValid[k] = oValid[k];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!(iReady[0] && iReady[1] && iReady[2] && !oValid[0] && !oValid[1] && !oValid[2]) && n < 40) begin
            step();
            n++;
        end
        check("idle_timeout", 128'(n < 40), 128'(1));
    endtask

    task automatic issue(input logic [127:0] vec, input logic [127:0] exp);
        waitIdle();
        inValid = 1'b1;
        dataIn  = vec;
        q0.push_back(exp);
        q1.push_back(exp);
        q2.push_back(exp);
        step();
        inValid = 1'b0;
        dataIn  = ~vec;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        dataIn   = '0;
`ifdef MIXCOL_BYPASS_EN
        bypassDrv = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_in_ready_dut%0d", k), 128'(iReady[k]), 128'(1));
            check($sformatf("reset_out_valid_dut%0d", k), 128'(oValid[k]), 128'(0));
            check($sformatf("reset_dataout_dut%0d", k), dOut[k], '0);
        end

        issue(V1, E1);
        waitIdle();
        issue(V2, E2);
        waitIdle();
        issue(V3, E3);
        waitIdle();

        // Backpressure: results held while in_valid/DataIn toggle
        outReady = 1'b0;
        issue(V1, E1);
        n = 0;
        while (!(oValid[0] && oValid[1] && oValid[2]) && n < 10) begin
            step();
            n++;
        end
        check("done_timeout", 128'(n < 10), 128'(1));
        for (int c = 0; c < 10; c++) begin
            inValid = 1'($urandom_range(0, 1));
            dataIn  = {$urandom, $urandom, $urandom, $urandom};
            step();
            for (int k = 0; k < 3; k++) begin
                check($sformatf("hold_dataout_dut%0d", k), dOut[k], E1);
                check($sformatf("hold_in_ready_dut%0d", k), 128'(iReady[k]), 128'(0));
                check($sformatf("hold_out_valid_dut%0d", k), 128'(oValid[k]), 128'(1));
            end
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("release_idle_dut%0d", k), 128'(iReady[k]), 128'(1));
            check($sformatf("release_out_valid_dut%0d", k), 128'(oValid[k]), 128'(0));
        end

        // Asynchronous reset while the one-column engine sits at counter 2
        issue(V3, E3);
        step();
        step();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async_rst_out_valid_dut%0d", k), 128'(oValid[k]), 128'(0));
            check($sformatf("async_rst_in_ready_dut%0d", k), 128'(iReady[k]), 128'(1));
            check($sformatf("async_rst_dataout_dut%0d", k), dOut[k], '0);
        end
        q0.delete();
        q1.delete();
        q2.delete();
        #1;
        rst = 1'b0;
        issue(V1, E1);
        waitIdle();

`ifdef MIXCOL_BYPASS_EN
        bypassDrv = 1'b1;
        issue(V1, V1);
        bypassDrv = 1'b0;
        waitIdle();
        issue(V1, E1);
        waitIdle();
`endif

        step();
        check("scoreboard_drained", 128'(q0.size() + q1.size() + q2.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
